// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with modulo limit, wrap/saturate mode, terminal-count pulse and sticky flags.
// Optional prescaler enabled by defining UDCNT_PRESCALE_EN (adds the prescale input).
module updown_counter_mod #(
  parameter int WIDTH      = 8,
  parameter int RESET_VAL  = 0,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      max_val,
  input  logic                  sat_mode,
  input  logic                  flag_clr,
`ifdef UDCNT_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      cnt,
  output logic                  tc,
  output logic                  ovf,
  output logic                  unf
);

  if (WIDTH < 2) begin : g_bad_width
    $error("updown_counter_mod: WIDTH must be >= 2");
  end
  if (PRESCALE_W < 1) begin : g_bad_prescale_w
    $error("updown_counter_mod: PRESCALE_W must be >= 1");
  end

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             step;

`ifdef UDCNT_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc_q, presc_d;

  // A step happens only on the enabled cycle where the prescaler has reached its compare value.
  assign step = en && (presc_q == prescale);
`else
  assign step = en;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q & ~flag_clr;
    unf_d = unf_q & ~flag_clr;
`ifdef UDCNT_PRESCALE_EN
    presc_d = presc_q;
`endif
    if (clr) begin
      cnt_d = '0;
`ifdef UDCNT_PRESCALE_EN
      presc_d = '0;
`endif
    end else if (load) begin
      cnt_d = load_val;
`ifdef UDCNT_PRESCALE_EN
      presc_d = '0;
`endif
    end else begin
`ifdef UDCNT_PRESCALE_EN
      if (en) begin
        presc_d = step ? '0 : presc_q + 1'b1;
      end
`endif
      if (step) begin
        // Flag sets are applied after the flag_clr default, so a set wins over a same-cycle clear.
        if (up) begin
          if (cnt_q >= max_val) begin
            cnt_d = sat_mode ? max_val : '0;
            ovf_d = 1'b1;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d = sat_mode ? '0 : max_val;
            unf_d = 1'b1;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_CNT;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
`ifdef UDCNT_PRESCALE_EN
      presc_q <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
`ifdef UDCNT_PRESCALE_EN
      presc_q <= presc_d;
`endif
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule
